// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state codes and ALU control codes shared by the multicycle MIPS control path.
// ADDI_EX/ADDI_WB codes are reserved here; they are only reachable when MULTICYCLE_ADDI_EN is defined.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_output_decode.sv
// rtl/multicycle_output_decode.sv - combinational state/mem_ready to datapath control decode.
// ADDI_EX/ADDI_WB outputs are decoded only when MULTICYCLE_ADDI_EN is defined.
module multicycle_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic       reset,
    input  state_t     cur_state,
    input  logic       mem_ready,
    input  logic       illegal,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        state       = 4'd0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        // Reset forces every control low so an abandoned instruction commits nothing.
        if (!reset) begin
            state = cur_state;
            case (cur_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = SRCB_BOFS;
                    illegal_op = illegal;
                    instr_done = illegal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_RTYPE_WB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
`ifdef MULTICYCLE_ADDI_EN
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_ADDI_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM: state register and next-state logic.
// Define MULTICYCLE_ADDI_EN to decode addi; otherwise it is treated as an unknown opcode.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    logic   illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            // Op is re-sampled here; anything other than sw proceeds as a load.
            S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    multicycle_output_decode u_decode (
        .reset       (reset),
        .cur_state   (state_q),
        .mem_ready   (mem_ready),
        .illegal     (illegal),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .state       (state),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed instruction sequences checked against a per-cycle expectation model.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rdst;
        logic [1:0] aluop, srcb, pcsrc;
        logic       done, ill;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic       rst;
        state_t     st;
        ctl_t       c;
    } cyc_t;

`ifdef MULTICYCLE_ADDI_EN
    localparam int ADDI_LAT = 4;
`else
    localparam int ADDI_LAT = 2;
`endif

    cyc_t q[$];
    int   lat_q[$];
    int   idx, cut_at;
    bit   stopped;
    int   errors = 0;
    int   checks = 0;
    ctl_t got;

    assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, instr_done, illegal_op};

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // A cut instruction is replaced by one reset cycle at cycle index cut_at.
    task automatic add(input logic [5:0] op, input logic rdy, input state_t st, input ctl_t c);
        cyc_t r;
        if (stopped) return;
        r.op  = op;
        r.rdy = rdy;
        if (idx == cut_at) begin
            r.rst   = 1'b1;
            r.st    = S_FETCH;
            r.c     = '0;
            stopped = 1'b1;
        end else begin
            r.rst = 1'b0;
            r.st  = st;
            r.c   = c;
        end
        q.push_back(r);
        idx++;
    endtask

    task automatic add_reset(input int n);
        cyc_t r;
        for (int i = 0; i < n; i++) begin
            r.op = rop(); r.rdy = rbit(); r.rst = 1'b1; r.st = S_FETCH; r.c = '0;
            q.push_back(r);
        end
    endtask

    task automatic build(input logic [5:0] op, input int wf, input int wm, input int cut);
        ctl_t c;
        bit   known;
        idx = 0; cut_at = cut; stopped = 1'b0;
        for (int i = 0; i < wf; i++) begin
            c = '0; c.mr = 1; c.srcb = 2'b01;
            add(rop(), 1'b0, S_FETCH, c);
        end
        c = '0; c.mr = 1; c.srcb = 2'b01; c.irw = 1; c.pcw = 1;
        add(rop(), 1'b1, S_FETCH, c);
        known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_J);
`ifdef MULTICYCLE_ADDI_EN
        known = known || (op == OP_ADDI);
`endif
        c = '0; c.srcb = 2'b11;
        if (!known) begin
            c.ill = 1; c.done = 1;
            add(op, rbit(), S_DECODE, c);
            return;
        end
        add(op, rbit(), S_DECODE, c);
        if (op == OP_LW || op == OP_SW) begin
            c = '0; c.srca = 1; c.srcb = 2'b10;
            add(op, rbit(), S_MEMADR, c);
            if (op == OP_LW) begin
                c = '0; c.mr = 1; c.iord = 1;
                for (int i = 0; i < wm; i++) add(rop(), 1'b0, S_MEMREAD, c);
                add(rop(), 1'b1, S_MEMREAD, c);
                c = '0; c.rw = 1; c.m2r = 1; c.done = 1;
                add(rop(), rbit(), S_MEMWB, c);
            end else begin
                c = '0; c.mw = 1; c.iord = 1;
                for (int i = 0; i < wm; i++) add(rop(), 1'b0, S_MEMWRITE, c);
                c.done = 1;
                add(rop(), 1'b1, S_MEMWRITE, c);
            end
        end else if (op == OP_RTYPE) begin
            c = '0; c.srca = 1; c.aluop = 2'b10;
            add(rop(), rbit(), S_EXECUTE, c);
            c = '0; c.rdst = 1; c.rw = 1; c.done = 1;
            add(rop(), rbit(), S_RTYPE_WB, c);
        end else if (op == OP_BEQ) begin
            c = '0; c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; c.done = 1;
            add(rop(), rbit(), S_BRANCH, c);
        end else if (op == OP_J) begin
            c = '0; c.pcw = 1; c.pcsrc = 2'b10; c.done = 1;
            add(rop(), rbit(), S_JUMP, c);
        end else begin
            c = '0; c.srca = 1; c.srcb = 2'b10;
            add(rop(), rbit(), S_ADDI_EX, c);
            c = '0; c.rw = 1; c.done = 1;
            add(rop(), rbit(), S_ADDI_WB, c);
        end
    endtask

    initial begin
        int   exp_lat[10];
        int   cnt;
        cyc_t r;
        exp_lat = '{5, 7, 3, 3, 2, 4, ADDI_LAT, 8, 7, 4};
        cnt = 0;

        add_reset(2);
        build(OP_LW, 0, 0, -1);
        build(OP_SW, 0, 3, -1);
        build(OP_BEQ, 0, 0, -1);
        build(OP_J, 0, 0, -1);
        build(6'b111111, 0, 0, -1);
        build(OP_RTYPE, 0, 0, -1);
        build(OP_ADDI, 0, 0, -1);
        build(OP_LW, 1, 2, -1);
        build(OP_RTYPE, 0, 0, 2);
        build(OP_LW, 0, 3, 4);
        build(OP_SW, 2, 1, -1);
        build(OP_RTYPE, 0, 0, -1);

        for (int n = 0; n < q.size(); n++) begin
            r = q[n];
            @(posedge clk);
            #1;
            reset = r.rst; Op = r.op; mem_ready = r.rdy;
            @(negedge clk);
            checks++;
            if (got !== r.c) begin
                errors++;
                $display("FAIL ctl cyc=%0d got=%h want=%h", n, got, r.c);
            end
            checks++;
            if (state !== 4'(r.st)) begin
                errors++;
                $display("FAIL state cyc=%0d got=%0d want=%0d", n, state, r.st);
            end
            checks++;
            if ((MemRead & MemWrite) !== 1'b0) begin
                errors++;
                $display("FAIL rdwr_excl cyc=%0d got=%b want=0", n, MemRead & MemWrite);
            end
            if (r.rst) begin
                cnt = 0;
            end else begin
                cnt++;
                if (instr_done === 1'b1) begin
                    lat_q.push_back(cnt);
                    cnt = 0;
                end
            end
        end

        checks++;
        if (lat_q.size() != 10) begin
            errors++;
            $display("FAIL lat_count got=%0d want=10", lat_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            if (i < lat_q.size()) begin
                checks++;
                if (lat_q[i] != exp_lat[i]) begin
                    errors++;
                    $display("FAIL latency instr=%0d got=%0d want=%0d", i, lat_q[i], exp_lat[i]);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
